// File: rtl/sprite_pixel_sink.sv
// sprite_pixel_sink
//   Consumer end of the sprite pixel stream. Accepts (x, y, colour, last)
//   pixels over a valid/ready handshake and drops pixels that are off-screen
//   or carry the transparent colour key. Kept pixels are buffered in a small
//   FIFO and replayed to the VGA adapter plot port whenever plot_enable
//   grants it. An end-of-sprite pulse is raised when the sprite's last pixel
//   leaves the FIFO, so completion is ordered behind the pixels already queued.
//
// Ports
//   clock_all      in   1   system clock, rising edge
//   reset_all      in   1   asynchronous active-low reset
//   pix_valid      in   1   pixel on pix_* is valid
//   pix_ready      out  1   sink can accept a pixel (count < DEPTH)
//   pix_x/y        in   9/8 absolute screen coordinates
//   pix_colour     in   3   pixel colour
//   pix_last       in   1   final pixel of the current sprite
//   plot_enable    in   1   VGA port grant; 0 stalls draining
//   clear_stats    in   1   synchronous clear of both counters
//   vga_x/y/colour out  9/8/3 plot data (held when nothing is popped)
//   vga_plot       out  1   write strobe to the VGA adapter
//   sprite_done    out  1   one-cycle pulse when the last pixel drains
//   busy           out  1   FIFO non-empty or a plot is being presented
//   kept_count     out  16  pixels plotted, saturating
//   dropped_count  out  16  pixels clipped or transparent, saturating
module sprite_pixel_sink #(
  parameter int         DEPTH      = 8,
  parameter int         ADDR_W     = 3,
  parameter int         SCREEN_W   = 320,
  parameter int         SCREEN_H   = 240,
  parameter bit         TRANSP_EN  = 1'b1,
  parameter logic [2:0] TRANSP_KEY = 3'b111
) (
  input  logic        clock_all,
  input  logic        reset_all,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [8:0]  pix_x,
  input  logic [7:0]  pix_y,
  input  logic [2:0]  pix_colour,
  input  logic        pix_last,
  input  logic        plot_enable,
  input  logic        clear_stats,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        sprite_done,
  output logic        busy,
  output logic [15:0] kept_count,
  output logic [15:0] dropped_count
);

  localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [8:0]      SCREEN_W_L = 9'(SCREEN_W);
  localparam logic [7:0]      SCREEN_H_L = 8'(SCREEN_H);

  typedef struct packed {
    logic       plot;
    logic       last;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;

  logic [8:0]  vga_x_q;
  logic [7:0]  vga_y_q;
  logic [2:0]  vga_colour_q;
  logic        vga_plot_q, sprite_done_q;
  logic [15:0] kept_q, dropped_q;

  logic   accept, drop, push, pop;
  entry_t wr_entry, rd_entry;

  assign pix_ready = (count_q < DEPTH_L);
  assign accept    = pix_valid & pix_ready;
  assign drop      = (pix_x >= SCREEN_W_L) | (pix_y >= SCREEN_H_L) |
                     (TRANSP_EN & (pix_colour == TRANSP_KEY));
  // A dropped last pixel still needs a slot so sprite_done stays behind
  // the pixels queued ahead of it; it goes in as a non-plotting marker.
  assign push      = accept & (~drop | pix_last);
  assign pop       = (count_q != '0) & plot_enable;

  assign wr_entry  = '{plot: ~drop, last: pix_last, x: pix_x, y: pix_y, colour: pix_colour};
  assign rd_entry  = mem_q[rd_ptr_q];

  // Storage carries no reset: stale contents are unreachable once count is 0.
  always_ff @(posedge clock_all) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Output stage: strobes are one-cycle, coordinates hold between plots.
  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_plot_q    <= 1'b0;
      sprite_done_q <= 1'b0;
    end else begin
      vga_plot_q    <= pop & rd_entry.plot;
      sprite_done_q <= pop & rd_entry.last;
      if (pop) begin
        vga_x_q      <= rd_entry.x;
        vga_y_q      <= rd_entry.y;
        vga_colour_q <= rd_entry.colour;
      end
    end
  end

  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      kept_q    <= '0;
      dropped_q <= '0;
    end else if (clear_stats) begin
      kept_q    <= '0;
      dropped_q <= '0;
    end else begin
      if (pop && rd_entry.plot && kept_q != 16'hFFFF)
        kept_q <= kept_q + 16'd1;
      if (accept && drop && dropped_q != 16'hFFFF)
        dropped_q <= dropped_q + 16'd1;
    end
  end

  assign vga_x         = vga_x_q;
  assign vga_y         = vga_y_q;
  assign vga_colour    = vga_colour_q;
  assign vga_plot      = vga_plot_q;
  assign sprite_done   = sprite_done_q;
  assign busy          = (count_q != '0) | vga_plot_q;
  assign kept_count    = kept_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_sprite_pixel_sink.sv
// tb_sprite_pixel_sink
//   Directed bench for sprite_pixel_sink. One linear initial block drives
//   the pixel stream; a negedge monitor records every plot and every
//   non-plotting sprite_done so ordering and counts can be checked.
module tb_sprite_pixel_sink;

  logic        clock_all, reset_all;
  logic        pix_valid, pix_ready;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [2:0]  pix_colour;
  logic        pix_last, plot_enable, clear_stats;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, sprite_done, busy;
  logic [15:0] kept_count, dropped_count;

  int vectors = 0;
  int miscompares = 0;

  sprite_pixel_sink dut (
    .clock_all(clock_all), .reset_all(reset_all),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .pix_last(pix_last),
    .plot_enable(plot_enable), .clear_stats(clear_stats),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .sprite_done(sprite_done), .busy(busy),
    .kept_count(kept_count), .dropped_count(dropped_count)
  );

  initial clock_all = 1'b0;
  always #5 clock_all = ~clock_all;

  // Monitor: {done, x, y, colour} per plot; markers = done without plot.
  logic        mon_en = 1'b1;
  logic [20:0] plot_q[$];
  int          marker_cnt = 0;
  always @(negedge clock_all) begin
    if (mon_en) begin
      if (vga_plot) plot_q.push_back({sprite_done, vga_x, vga_y, vga_colour});
      else if (sprite_done) marker_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock_all);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input int c, input logic last);
    pix_valid  = 1'b1;
    pix_x      = 9'(x);
    pix_y      = 8'(y);
    pix_colour = 3'(c);
    pix_last   = last;
  endtask

  // Present one pixel and hold it until it transfers (bounded wait).
  task automatic send(input int x, input int y, input int c, input logic last);
    int waited;
    drive(x, y, c, last);
    waited = 0;
    while (!pix_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!pix_ready) chk("send_timeout", 32'(pix_ready), 32'd1);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic clear_counters();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
  endtask

  initial begin
    int pbase, mbase, gaps, plots, markers;
    logic [20:0] e;

    reset_all = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    pix_colour = '0; pix_last = 1'b0; plot_enable = 1'b0; clear_stats = 1'b0;

    // Reset state
    #2;
    chk("rst_ready", 32'(pix_ready), 32'd1);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_done", 32'(sprite_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_kept", 32'(kept_count), 32'd0);
    chk("rst_drop", 32'(dropped_count), 32'd0);
    #6 reset_all = 1'b1;
    tick();

    // Four-pixel sprite: plots start two edges after first accept
    plot_enable = 1'b1;
    drive(10, 20, 3, 1'b0); tick();
    chk("s2_c0_plot", 32'(vga_plot), 32'd0);
    drive(11, 20, 3, 1'b0); tick();
    chk("s2_c1_plot", 32'(vga_plot), 32'd1);
    chk("s2_c1_x", 32'(vga_x), 32'd10);
    chk("s2_c1_done", 32'(sprite_done), 32'd0);
    drive(12, 20, 3, 1'b0); tick();
    chk("s2_c2_x", 32'({vga_plot, vga_x}), 32'h20B);
    drive(13, 20, 3, 1'b1); tick();
    chk("s2_c3_x", 32'({vga_plot, vga_x}), 32'h20C);
    pix_valid = 1'b0; tick();
    chk("s2_c4_x", 32'({vga_plot, vga_x}), 32'h20D);
    chk("s2_c4_yc", 32'({vga_y, vga_colour}), 32'({8'd20, 3'd3}));
    chk("s2_c4_done", 32'(sprite_done), 32'd1);
    chk("s2_kept", 32'(kept_count), 32'd4);
    tick();
    chk("s2_idle_plot", 32'(vga_plot), 32'd0);
    chk("s2_idle_busy", 32'(busy), 32'd0);

    // Reset with 5 entries buffered
    plot_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(30 + i, 40, 2, i == 4);
      tick();
    end
    pix_valid = 1'b0;
    chk("s1_busy_before", 32'(busy), 32'd1);
    #2 reset_all = 1'b0;
    #1;
    chk("s1_ready", 32'(pix_ready), 32'd1);
    chk("s1_busy", 32'(busy), 32'd0);
    chk("s1_plot", 32'(vga_plot), 32'd0);
    chk("s1_kept", 32'(kept_count), 32'd0);
    @(negedge clock_all) reset_all = 1'b1;
    pbase = plot_q.size(); mbase = marker_cnt;
    plot_enable = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("s1_no_plots", 32'(plot_q.size() - pbase), 32'd0);
    chk("s1_no_done", 32'(marker_cnt - mbase), 32'd0);

    // Backpressure: 9 pixels into an 8-deep FIFO with draining stalled
    plot_enable = 1'b0;
    pbase = plot_q.size(); mbase = marker_cnt;
    for (int i = 0; i < 9; i++) begin
      drive(i, 50, 1, i == 8);
      chk($sformatf("s3_ready_%0d", i), 32'(pix_ready), 32'(i < 8));
      if (i < 8) tick();
    end
    tick(); tick();
    chk("s3_held", 32'(pix_ready), 32'd0);
    plot_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      automatic logic acc = pix_valid & pix_ready;
      tick();
      if (acc) pix_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) tick();
    chk("s3_nplots", 32'(plot_q.size() - pbase), 32'd9);
    for (int i = 0; i < 9; i++) begin
      e = (pbase + i < plot_q.size()) ? plot_q[pbase + i] : 21'h1FFFFF;
      chk($sformatf("s3_plot_%0d", i), 32'(e),
          32'({(i == 8), 9'(i), 8'd50, 3'd1}));
    end
    chk("s3_kept", 32'(kept_count), 32'd9);

    // Clipping and transparency
    clear_counters();
    pbase = plot_q.size(); mbase = marker_cnt;
    send(319, 10, 2, 1'b0);
    send(320, 10, 2, 1'b0);
    send(5, 240, 2, 1'b0);
    send(5, 10, 7, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    plots = plot_q.size() - pbase; markers = marker_cnt - mbase;
    chk("s4_nplots", 32'(plots), 32'd1);
    e = (plots > 0) ? plot_q[pbase] : 21'h1FFFFF;
    chk("s4_plot", 32'(e), 32'({1'b0, 9'd319, 8'd10, 3'd2}));
    chk("s4_marker", 32'(markers), 32'd1);
    chk("s4_dropped", 32'(dropped_count), 32'd3);
    chk("s4_kept", 32'(kept_count), 32'd1);

    // Transparent last pixel after two kept pixels
    clear_counters();
    pbase = plot_q.size(); mbase = marker_cnt;
    send(1, 1, 2, 1'b0);
    send(2, 1, 2, 1'b0);
    send(3, 1, 7, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    plots = plot_q.size() - pbase;
    chk("s5_nplots", 32'(plots), 32'd2);
    e = (plots > 1) ? plot_q[pbase + 1] : 21'h1FFFFF;
    chk("s5_plot1", 32'(e), 32'({1'b0, 9'd2, 8'd1, 3'd2}));
    chk("s5_marker", 32'(marker_cnt - mbase), 32'd1);
    chk("s5_dropped", 32'(dropped_count), 32'd1);

    // Sustained full-rate stream, clear override, kept_count saturation
    mon_en = 1'b0;
    clear_counters();
    plot_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(7, 7, 1, 1'b0);
      tick();
    end
    chk("s6_full", 32'(pix_ready), 32'd0);
    plot_enable = 1'b1;
    tick();
    chk("s6_ready_after_pop", 32'(pix_ready), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("s6_kept5", 32'(kept_count), 32'd5);
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    chk("s6_clr_override", 32'(kept_count), 32'd0);
    tick();
    chk("s6_kept1", 32'(kept_count), 32'd1);
    gaps = 0;
    for (int i = 0; i < 65540; i++) begin
      if (!vga_plot || !pix_ready) gaps++;
      tick();
    end
    chk("s6_no_gaps", 32'(gaps), 32'd0);
    chk("s6_sat", 32'(kept_count), 32'h0000FFFF);
    tick(); tick(); tick();
    chk("s6_sat_hold", 32'(kept_count), 32'h0000FFFF);
    pix_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("s6_drained", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
